// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants and state encoding for the writeback arbiter
// Purpose: requester count, scoreboard counter width, register/data widths, FSM states.
// Ports: none (package).
package rf_wb_arbiter_pkg;

  localparam int NREQ = 3;
  localparam int SBW  = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request bus shared by all requesters
// Purpose: bundles per-requester valid/ready handshake with packed address and data.
// Ports: wb_valid/wb_waddr/wb_wdata driven by master, wb_ready driven by slave.
interface rf_wb_arbiter_if #(
  parameter int NREQ = rf_wb_arbiter_pkg::NREQ
);
  import rf_wb_arbiter_pkg::*;

  logic [NREQ-1:0]    wb_valid;
  logic [NREQ-1:0]    wb_ready;
  logic [AW*NREQ-1:0] wb_waddr;
  logic [DW*NREQ-1:0] wb_wdata;

  modport master (
    output wb_valid,
    output wb_waddr,
    output wb_wdata,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_waddr,
    input  wb_wdata,
    output wb_ready
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rtl/rf_wb_arbiter_rr_arbiter.sv - N-way round-robin grant with rotating priority pointer
// Purpose: one-hot grant among asserted requests, search starting at pointer rr.
// Ports: clk, resetn; req in; grant (one-hot), grant_idx, grant_valid out.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] rr_q;

  // First asserted request at or after rr (wrapping) wins.
  always_comb begin
    logic [IW-1:0] k;
    k           = '0;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < N; off++) begin
      k = IW'((int'(rr_q) + off) % N);
      if (!grant_valid && req[k]) begin
        grant[k]    = 1'b1;
        grant_idx   = k;
        grant_valid = 1'b1;
      end
    end
  end

  // Priority moves just past the winner so it becomes lowest next time.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rr_q <= '0;
    end else if (grant_valid) begin
      rr_q <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - writeback arbiter with register scoreboard and drain FSM
// Purpose: round-robin writeback into the regfile, per-register pending counters,
//          RUN/DRAIN flow that blocks issue until every pending write has landed.
// Ports: clk, resetn; wb (slave, writeback requests); rf_wen/rf_waddr/rf_wdata registered
//        write port; iss_valid/iss_ready/iss_waddr issue reservation; rs1/rs2 busy lookup;
//        flush in, drained single-cycle pulse out.
module rf_wb_arbiter #(
  parameter int NREQ = rf_wb_arbiter_pkg::NREQ,
  parameter int SBW  = rf_wb_arbiter_pkg::SBW
) (
  input  logic                             clk,
  input  logic                             resetn,
  rf_wb_arbiter_if.slave                   wb,
  output logic                             rf_wen,
  output logic [rf_wb_arbiter_pkg::AW-1:0] rf_waddr,
  output logic [rf_wb_arbiter_pkg::DW-1:0] rf_wdata,
  input  logic                             iss_valid,
  output logic                             iss_ready,
  input  logic [rf_wb_arbiter_pkg::AW-1:0] iss_waddr,
  input  logic [rf_wb_arbiter_pkg::AW-1:0] rs1_addr,
  input  logic [rf_wb_arbiter_pkg::AW-1:0] rs2_addr,
  output logic                             rs1_busy,
  output logic                             rs2_busy,
  input  logic                             flush,
  output logic                             drained
);
  import rf_wb_arbiter_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SBW-1:0] CNT_MAX = '1;

  logic [IW-1:0]  grant_idx;
  logic           grant_valid;
  logic [AW-1:0]  wb_sel_addr;
  logic [DW-1:0]  wb_sel_data;
  logic           wb_acc;
  logic           iss_acc;

  logic [SBW-1:0] cnt_q [NREG-1:1];
  logic [NREG-1:0] nz;
  logic [NREG-1:0] full;
  logic [NREG-1:1] inc;
  logic [NREG-1:1] dec;
  logic            all_idle;

  state_t state_q, state_d;

  rr_arbiter #(.N(NREQ)) u_rr_arbiter (
    .clk         (clk),
    .resetn      (resetn),
    .req         (wb.wb_valid),
    .grant       (wb.wb_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign wb_sel_addr = wb.wb_waddr[grant_idx*AW +: AW];
  assign wb_sel_data = wb.wb_wdata[grant_idx*DW +: DW];
  // r0 writes complete the handshake but never touch the regfile or scoreboard.
  assign wb_acc      = grant_valid && (wb_sel_addr != '0);

  // Bit 0 of nz/full stays 0 so r0 is never busy and never blocks issue.
  always_comb begin
    nz   = '0;
    full = '0;
    for (int r = 1; r < NREG; r++) begin
      nz[r]   = (cnt_q[r] != '0);
      full[r] = (cnt_q[r] == CNT_MAX);
    end
  end

  assign all_idle  = ~|nz;
  assign iss_ready = (state_q == RUN) && !full[iss_waddr];
  assign iss_acc   = iss_valid && iss_ready && (iss_waddr != '0);
  assign rs1_busy  = nz[rs1_addr];
  assign rs2_busy  = nz[rs2_addr];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      inc[r] = iss_acc && (iss_waddr == AW'(r));
      dec[r] = wb_acc && (wb_sel_addr == AW'(r));
    end
  end

  // Same-cycle issue and writeback cancel; a decrement at zero is dropped.
  always_ff @(posedge clk) begin
    for (int r = 1; r < NREG; r++) begin
      if (!resetn) begin
        cnt_q[r] <= '0;
      end else if (inc[r] && !dec[r]) begin
        cnt_q[r] <= cnt_q[r] + 1'b1;
      end else if (dec[r] && !inc[r] && nz[r]) begin
        cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= wb_acc;
      if (grant_valid) begin
        rf_waddr <= wb_sel_addr;
        rf_wdata <= wb_sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // drained is a Moore output: high in the one DRAIN cycle that sees an empty scoreboard.
  always_comb begin
    state_d = state_q;
    drained = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_idle) begin
          state_d = RUN;
          drained = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_waddr;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        flush;
  logic        drained;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.NREQ(3)) wbif ();

  rf_wb_arbiter #(.NREQ(3), .SBW(2)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wb        (wbif),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_waddr (iss_waddr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .flush     (flush),
    .drained   (drained)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: pending count per register, rotating start, drain flag.
  int          m_cnt [32];
  int          m_rr;
  bit          m_drain;
  bit          m_rf_wen;
  logic [4:0]  m_rf_waddr;
  logic [31:0] m_rf_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_rr       = 0;
    m_drain    = 0;
    m_rf_wen   = 0;
    m_rf_waddr = '0;
    m_rf_wdata = '0;
  endtask

  function automatic int model_grant();
    for (int off = 0; off < 3; off++) begin
      if (wbif.wb_valid[(m_rr + off) % 3]) return (m_rr + off) % 3;
    end
    return -1;
  endfunction

  task automatic idle();
    wbif.wb_valid = '0;
    wbif.wb_waddr = '0;
    wbif.wb_wdata = '0;
    iss_valid = 1'b0;
    iss_waddr = '0;
    flush     = 1'b0;
    rs1_addr  = '0;
    rs2_addr  = '0;
  endtask

  task automatic set_wb(input int i, input logic [4:0] a, input logic [31:0] d);
    wbif.wb_valid[i]        = 1'b1;
    wbif.wb_waddr[i*5 +: 5]  = a;
    wbif.wb_wdata[i*32 +: 32] = d;
  endtask

  // Called just after a falling edge with inputs applied: compare, advance model, run one cycle.
  task automatic step();
    int          g;
    int          a;
    int          old;
    int          inc;
    int          dec;
    logic [31:0] d;
    logic [2:0]  eg;
    bit          e_iss;
    bit          all_zero;
    #1;
    g  = model_grant();
    eg = (g >= 0) ? 3'(1 << g) : 3'b000;
    e_iss = !m_drain && ((iss_waddr == 0) || (m_cnt[iss_waddr] < 3));
    all_zero = 1;
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) all_zero = 0;
    check("wb_ready", 32'(wbif.wb_ready), 32'(eg));
    check("iss_ready", 32'(iss_ready), 32'(e_iss));
    check("rs1_busy", 32'(rs1_busy), 32'((rs1_addr != 0) && (m_cnt[rs1_addr] != 0)));
    check("rs2_busy", 32'(rs2_busy), 32'((rs2_addr != 0) && (m_cnt[rs2_addr] != 0)));
    check("drained", 32'(drained), 32'(m_drain && all_zero));
    check("rf_wen", 32'(rf_wen), 32'(m_rf_wen));
    check("rf_waddr", 32'(rf_waddr), 32'(m_rf_waddr));
    check("rf_wdata", rf_wdata, m_rf_wdata);
    if (!resetn) begin
      reset_model();
    end else begin
      a = -1;
      d = '0;
      if (g >= 0) begin
        a = int'(wbif.wb_waddr[g*5 +: 5]);
        d = wbif.wb_wdata[g*32 +: 32];
        m_rf_wen   = (a != 0);
        m_rf_waddr = 5'(a);
        m_rf_wdata = d;
        m_rr       = (g + 1) % 3;
      end else begin
        m_rf_wen = 0;
      end
      for (int r = 1; r < 32; r++) begin
        old = m_cnt[r];
        inc = (iss_valid && e_iss && (int'(iss_waddr) == r)) ? 1 : 0;
        dec = (a == r && (old + inc) > 0) ? 1 : 0;
        m_cnt[r] = old + inc - dec;
      end
      if (!m_drain && flush) m_drain = 1;
      else if (m_drain && all_zero) m_drain = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  int exp_g [4] = '{1, 2, 4, 1};
  int exp_a [4] = '{1, 2, 3, 1};

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    reset_model();

    // Reset state
    rs1_addr  = 5'd1;
    iss_waddr = 5'd1;
    #1;
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_drained", 32'(drained), 32'd0);
    check("rst_busy", 32'(rs1_busy), 32'd0);
    check("rst_iss_ready", 32'(iss_ready), 32'd1);

    // Round-robin with all three requesters held
    idle();
    set_wb(0, 5'd1, 32'h100);
    set_wb(1, 5'd2, 32'h200);
    set_wb(2, 5'd3, 32'h300);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_grant", 32'(wbif.wb_ready), 32'(exp_g[i]));
      step();
      check("rr_waddr", 32'(rf_waddr), 32'(exp_a[i]));
    end

    // Two issues then two writebacks to r5
    idle();
    rs1_addr  = 5'd5;
    iss_valid = 1'b1;
    iss_waddr = 5'd5;
    step();
    step();
    iss_valid = 1'b0;
    set_wb(0, 5'd5, 32'h55);
    step();
    check("r5_busy_one_left", 32'(rs1_busy), 32'd1);
    step();
    idle();
    rs1_addr = 5'd5;
    #1;
    check("r5_busy_cleared", 32'(rs1_busy), 32'd0);

    // Counter saturation on r7
    idle();
    iss_valid = 1'b1;
    iss_waddr = 5'd7;
    repeat (3) step();
    iss_valid = 1'b0;
    #1;
    check("r7_full_blocks", 32'(iss_ready), 32'd0);
    iss_waddr = 5'd8;
    #1;
    check("r8_not_blocked", 32'(iss_ready), 32'd1);
    step();
    idle();
    set_wb(1, 5'd7, 32'h77);
    repeat (3) step();
    idle();
    rs2_addr = 5'd7;
    #1;
    check("r7_drained_out", 32'(rs2_busy), 32'd0);

    // Writeback to r0
    idle();
    set_wb(2, 5'd0, 32'hDEADBEEF);
    #1;
    check("r0_wb_ready", 32'(wbif.wb_ready), 32'b100);
    step();
    check("r0_no_wen", 32'(rf_wen), 32'd0);

    // Flush with two pending writes
    idle();
    iss_valid = 1'b1;
    iss_waddr = 5'd9;
    step();
    iss_waddr = 5'd10;
    step();
    iss_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    iss_waddr = 5'd9;
    #1;
    check("drain_blocks_issue", 32'(iss_ready), 32'd0);
    set_wb(0, 5'd9, 32'h99);
    step();
    check("drain_not_yet", 32'(drained), 32'd0);
    idle();
    set_wb(0, 5'd10, 32'hAA);
    step();
    idle();
    iss_waddr = 5'd9;
    #1;
    check("drained_pulse", 32'(drained), 32'd1);
    step();
    check("drained_one_cycle", 32'(drained), 32'd0);
    check("run_after_drain", 32'(iss_ready), 32'd1);

    // Reset while draining with r4 pending
    idle();
    iss_valid = 1'b1;
    iss_waddr = 5'd4;
    step();
    iss_valid = 1'b0;
    flush     = 1'b1;
    step();
    flush = 1'b0;
    set_wb(1, 5'd4, 32'h44);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    idle();
    rs1_addr  = 5'd4;
    iss_waddr = 5'd4;
    #1;
    check("rst_mid_busy", 32'(rs1_busy), 32'd0);
    check("rst_mid_wen", 32'(rf_wen), 32'd0);
    check("rst_mid_run", 32'(iss_ready), 32'd1);
    check("rst_mid_drained", 32'(drained), 32'd0);
    step();

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      idle();
      resetn = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 1) == 1) set_wb(i, 5'($urandom_range(0, 15)), $urandom);
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_waddr = 5'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 19) == 0);
      rs1_addr  = 5'($urandom_range(0, 15));
      rs2_addr  = 5'($urandom_range(0, 15));
      step();
    end
    resetn = 1'b1;
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of writeback requesters (fixed at 3 this release).
REQ-002 Parameter SBW, default 2, width of each per-register pending counter.
REQ-003 clk  in  1  single clock, all state updates on rising edge.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 wb_valid  in  NREQ  per-requester writeback request.
REQ-006 wb_ready  out  NREQ  per-requester grant; transfer when valid&ready.
REQ-007 wb_waddr  in  5*NREQ  destination register, requester i at bits [5i+4:5i].
REQ-008 wb_wdata  in  32*NREQ  write data, requester i at bits [32i+31:32i].
REQ-009 rf_wen / rf_waddr / rf_wdata  out  1/5/32  registered regfile write port.
REQ-010 iss_valid / iss_ready / iss_waddr  in/out/in  1/1/5  issue-side reservation of a destination register.
REQ-011 rs1_addr, rs2_addr  in  5 each  source registers to check; rs1_busy, rs2_busy  out  1 each.
REQ-012 flush  in  1  drain request; drained  out  1  single-cycle completion pulse.

Function
REQ-013 Arbiter SHALL grant at most one wb_ready per cycle, round-robin among asserted wb_valid, starting search at pointer rr.
REQ-014 rr SHALL advance to (granted index + 1) mod NREQ after each grant and hold when no grant.
REQ-015 wb_ready SHALL be combinational from wb_valid and rr; wb_ready[i] never asserted without wb_valid[i].
REQ-016 Accepted write SHALL appear on rf_wen/rf_waddr/rf_wdata exactly 1 cycle after acceptance; rf_wen low in cycles with no acceptance.
REQ-017 Accepted write with waddr 0 SHALL complete handshake but drive rf_wen 0.
REQ-018 Scoreboard SHALL hold one SBW-bit counter per register 1..31; register 0 has none and is never busy.
REQ-019 iss_ready SHALL be 1 in RUN when counter[iss_waddr] below 2^SBW-1 or iss_waddr is 0; 0 otherwise.
REQ-020 Issue accept (iss_valid&iss_ready, nonzero addr) SHALL increment counter; writeback accept SHALL decrement counter[waddr] if nonzero.
REQ-021 Simultaneous issue and writeback to same register SHALL leave counter unchanged.
REQ-022 Writeback to a register with counter 0 SHALL still be written and leave counter at 0 (no underflow).
REQ-023 rsN_busy SHALL equal (counter[rsN_addr] != 0), from registered counters only; no same-cycle bypass.
REQ-024 FSM states RUN, DRAIN: RUN->DRAIN on flush; DRAIN->RUN when all counters zero, asserting drained for that one cycle.
REQ-025 In DRAIN iss_ready SHALL be 0; writeback arbitration continues unchanged.
REQ-026 flush asserted while in DRAIN SHALL be ignored; flush in RUN with all counters zero SHALL enter DRAIN and pulse drained on the next cycle.

Reset
REQ-027 On resetn low at clk edge: state RUN, rr 0, all counters 0, rf_wen 0, rf_waddr 0, rf_wdata 0, drained 0.
REQ-028 Reset mid-DRAIN or with pending writes SHALL discard all state; no rf write issued the following cycle.

Structure
REQ-029 Shared package holds NREQ, SBW, register-address width 5, data width 32, state encoding RUN=0, DRAIN=1.
REQ-030 One sub-module rr_arbiter (NREQ-way round-robin grant, pointer update) is natural; scoreboard and FSM stay in top.

Verification
REQ-031 All three wb_valid held high, distinct addrs 1/2/3 -> grants 0,1,2,0 on consecutive cycles; rf_waddr 1,2,3,1 one cycle later.
REQ-032 Issue r5 twice, then wb r5 once -> rs1_busy (rs1_addr=5) stays 1; second wb r5 -> rs1_busy 0 next cycle.
REQ-033 Issue r7 three times (SBW=2) -> iss_ready 0 for iss_waddr 7, 1 for iss_waddr 8.
REQ-034 wb to r0 with data 0xDEADBEEF -> wb_ready 1, rf_wen 0 next cycle.
REQ-035 Two issues pending, pulse flush -> iss_ready 0; after both wbs, drained high exactly one cycle, then iss_ready 1.
REQ-036 resetn low in DRAIN with r4 pending -> next cycle RUN, rs1_busy(4) 0, rf_wen 0.
